// File: rtl/multi_cycle_ctrl_pkg.sv
// Shared decode constants, encodings and FSM state type for the multi-cycle control unit.
// Consumed by multi_cycle_ctrl and by the ALU/datapath that decode its select outputs.
package multi_cycle_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_OR    = 6'b100101;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_OR   = 3'b010;
  localparam logic [2:0] ALU_BEQ  = 3'b011;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_BRANCH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC_R,
    ST_EXEC_I,
    ST_MEM_ADDR,
    ST_MEM_RD,
    ST_MEM_WR,
    ST_WB_R,
    ST_WB_I,
    ST_WB_MEM,
    ST_BRANCH,
    ST_JUMP,
    ST_ERROR,
    ST_TRAP
  } state_e;

  // Unrecognised funct codes fall back to add.
  function automatic logic [2:0] funct_alu_op(input logic [5:0] funct);
    case (funct)
      FN_ADD:  return ALU_ADD;
      FN_SUB:  return ALU_SUB;
      FN_OR:   return ALU_OR;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/multi_cycle_ctrl_mem_wait_timer.sv
// Memory wait counter: counts consecutive not-ready cycles in a memory state and flags
// timeout on the cycle the count would reach TIMEOUT (TIMEOUT = 0 disables the timeout).
module mem_wait_timer #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic active_i,
  input  logic ready_i,
  output logic timeout_o
);

  localparam int unsigned W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Any exit from a memory state needs ready (or times out), so clearing on ready or
  // outside memory states also clears the count on entry to the next memory state.
  always_comb begin
    cnt_d = '0;
    if (active_i && !ready_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign timeout_o = (TIMEOUT != 0) && active_i && !ready_i && (cnt_q == W'(TIMEOUT - 1));

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS-subset control FSM with memory-timeout error and retired counter.
// Define ILLEGAL_TRAP_EN to trap on unknown opcodes (adds the trap output port).
module multi_cycle_ctrl
  import multi_cycle_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             reg_we,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic             imm_zext,
  output logic [2:0]       alu_op,
  output logic             err,
`ifdef ILLEGAL_TRAP_EN
  output logic             trap,
`endif
  output logic [CNT_W-1:0] retired
);

  state_e             state_q;
  state_e             state_d;
  logic [CNT_W-1:0]   retired_q;
  logic               retire_d;
  logic               mem_active;
  logic               timeout;

  assign mem_active = (state_q == ST_FETCH) || (state_q == ST_MEM_RD) || (state_q == ST_MEM_WR);

  mem_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk       (clk),
    .rst       (rst),
    .active_i  (mem_active),
    .ready_i   (mem_ready),
    .timeout_o (timeout)
  );

  always_comb begin
    state_d  = state_q;
    retire_d = 1'b0;
    case (state_q)
      ST_FETCH: begin
        if (mem_ready)    state_d = ST_DECODE;
        else if (timeout) state_d = ST_ERROR;
      end
      ST_DECODE: begin
        case (opcode)
          OP_RTYPE:     state_d = ST_EXEC_R;
          OP_LW, OP_SW: state_d = ST_MEM_ADDR;
          OP_ORI:       state_d = ST_EXEC_I;
          OP_BEQ:       state_d = ST_BRANCH;
          OP_J:         state_d = ST_JUMP;
`ifdef ILLEGAL_TRAP_EN
          default:      state_d = ST_TRAP;
`else
          default:      state_d = ST_FETCH;
`endif
        endcase
      end
      ST_EXEC_R:   state_d = ST_WB_R;
      ST_EXEC_I:   state_d = ST_WB_I;
      ST_MEM_ADDR: state_d = (opcode == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
      ST_MEM_RD: begin
        if (mem_ready)    state_d = ST_WB_MEM;
        else if (timeout) state_d = ST_ERROR;
      end
      ST_MEM_WR: begin
        if (mem_ready) begin
          state_d  = ST_FETCH;
          retire_d = 1'b1;
        end else if (timeout) begin
          state_d  = ST_ERROR;
        end
      end
      ST_WB_R, ST_WB_I, ST_WB_MEM, ST_BRANCH, ST_JUMP: begin
        state_d  = ST_FETCH;
        retire_d = 1'b1;
      end
      ST_ERROR, ST_TRAP: state_d = state_q;
      default:           state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_FETCH;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire_d) retired_q <= retired_q + 1'b1;
    end
  end

  assign retired = retired_q;

  // Outputs decode from state_q (plus mem_ready/zero for the gated enables) and are
  // forced low while rst is high so an in-flight request drops without waiting for a clock.
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_src     = PCSRC_ALU;
    reg_we     = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REG;
    imm_zext   = 1'b0;
    alu_op     = ALU_ADD;
    err        = 1'b0;
`ifdef ILLEGAL_TRAP_EN
    trap       = 1'b0;
`endif
    if (!rst) begin
      case (state_q)
        ST_FETCH: begin
          mem_req   = 1'b1;
          alu_src_b = SRCB_FOUR;
          ir_we     = mem_ready;
          pc_we     = mem_ready;
        end
        ST_DECODE: alu_src_b = SRCB_BRANCH;
        ST_EXEC_R: begin
          alu_src_a = 1'b1;
          alu_op    = funct_alu_op(funct);
        end
        ST_EXEC_I: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          imm_zext  = 1'b1;
          alu_op    = ALU_OR;
        end
        ST_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
        end
        ST_MEM_RD: begin
          mem_req = 1'b1;
          iord    = 1'b1;
        end
        ST_MEM_WR: begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
          iord    = 1'b1;
        end
        ST_WB_R: begin
          reg_we  = 1'b1;
          reg_dst = 1'b1;
        end
        ST_WB_I: reg_we = 1'b1;
        ST_WB_MEM: begin
          reg_we     = 1'b1;
          mem_to_reg = 1'b1;
        end
        ST_BRANCH: begin
          alu_src_a = 1'b1;
          alu_op    = ALU_BEQ;
          pc_src    = PCSRC_ALUOUT;
          pc_we     = zero;
        end
        ST_JUMP: begin
          pc_src = PCSRC_JUMP;
          pc_we  = 1'b1;
        end
        ST_ERROR: err = 1'b1;
`ifdef ILLEGAL_TRAP_EN
        ST_TRAP:  trap = 1'b1;
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Self-checking bench for multi_cycle_ctrl: directed scenarios plus a random instruction
// stream checked cycle by cycle against an instruction-level reference model.
module tb_multi_cycle_ctrl;

  localparam int TO = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [5:0]    opcode = '0;
  logic [5:0]    funct = '0;
  logic          zero = 1'b0;
  logic          mem_ready = 1'b0;
  logic          mem_req, mem_we, iord, ir_we, pc_we, reg_we, reg_dst, mem_to_reg;
  logic          alu_src_a, imm_zext, err;
  logic [1:0]    pc_src, alu_src_b;
  logic [2:0]    alu_op;
  logic [CW-1:0] retired;
`ifdef ILLEGAL_TRAP_EN
  logic          trap;
`endif

  multi_cycle_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
    .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .reg_we(reg_we), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .imm_zext(imm_zext), .alu_op(alu_op), .err(err),
`ifdef ILLEGAL_TRAP_EN
    .trap(trap),
`endif
    .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_src;
    logic       reg_we;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       imm_zext;
    logic [2:0] alu_op;
    logic       err;
  } ctl_t;

  ctl_t obs;
  assign obs = {mem_req, mem_we, iord, ir_we, pc_we, pc_src, reg_we, reg_dst, mem_to_reg,
                alu_src_a, alu_src_b, imm_zext, alu_op, err};

  int n_cmp = 0;
  int n_bad = 0;
  int exp_ret = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  function automatic bit rb();
    return 1'($urandom);
  endfunction

  function automatic logic [2:0] exp_alu(input logic [5:0] fn);
    if (fn == 6'h20) return 3'd0;
    if (fn == 6'h22) return 3'd1;
    if (fn == 6'h25) return 3'd2;
    return 3'd0;
  endfunction

  // One clock: drive inputs just after the edge, compare mid-cycle, then advance.
  task automatic step(input string tag, input bit r, input bit z, input ctl_t want);
    mem_ready = r;
    zero      = z;
    #1;
    chk(tag, {14'b0, obs}, {14'b0, want});
    @(posedge clk);
    #1;
  endtask

  task automatic mem_wait(input string tag, input ctl_t base, input bit fetch, input int waits);
    ctl_t c;
    for (int i = 0; i < waits; i++) step(tag, 1'b0, rb(), base);
    c = base;
    if (fetch) begin
      c.ir_we = 1'b1;
      c.pc_we = 1'b1;
    end
    step(tag, 1'b1, rb(), c);
  endtask

  function automatic ctl_t v_fetch();
    ctl_t c = '0;
    c.mem_req   = 1'b1;
    c.alu_src_b = 2'b01;
    return c;
  endfunction

  task automatic retire_one();
    exp_ret = (exp_ret + 1) % (1 << CW);
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int fw,
                           input int mw, input bit bz);
    ctl_t c;
    opcode = op;
    funct  = fn;
    mem_wait("fetch", v_fetch(), 1'b1, fw);
    c = '0; c.alu_src_b = 2'b11;
    step("decode", rb(), rb(), c);
    case (op)
      6'h00: begin
        c = '0; c.alu_src_a = 1'b1; c.alu_op = exp_alu(fn);
        step("exec_r", rb(), rb(), c);
        c = '0; c.reg_we = 1'b1; c.reg_dst = 1'b1;
        step("wb_r", rb(), rb(), c);
        retire_one();
      end
      6'h0d: begin
        c = '0; c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.imm_zext = 1'b1; c.alu_op = 3'd2;
        step("exec_i", rb(), rb(), c);
        c = '0; c.reg_we = 1'b1;
        step("wb_i", rb(), rb(), c);
        retire_one();
      end
      6'h23, 6'h2b: begin
        c = '0; c.alu_src_a = 1'b1; c.alu_src_b = 2'b10;
        step("mem_addr", rb(), rb(), c);
        c = '0; c.mem_req = 1'b1; c.iord = 1'b1; c.mem_we = (op == 6'h2b);
        mem_wait(op == 6'h2b ? "mem_wr" : "mem_rd", c, 1'b0, mw);
        if (op == 6'h23) begin
          c = '0; c.reg_we = 1'b1; c.mem_to_reg = 1'b1;
          step("wb_mem", rb(), rb(), c);
        end
        retire_one();
      end
      6'h04: begin
        c = '0; c.alu_src_a = 1'b1; c.alu_op = 3'd3; c.pc_src = 2'b01; c.pc_we = bz;
        step("branch", rb(), bz, c);
        retire_one();
      end
      6'h02: begin
        c = '0; c.pc_src = 2'b10; c.pc_we = 1'b1;
        step("jump", rb(), rb(), c);
        retire_one();
      end
      default: ;
    endcase
    chk("retired", 32'(retired), 32'(exp_ret));
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    #2;
    chk("rst_ctl", {14'b0, obs}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_ret = 0;
    chk("rst_retired", 32'(retired), 32'd0);
  endtask

  initial begin
    logic [5:0] ops [7];
    logic [5:0] fns [4];
    logic [5:0] op;
    logic [5:0] fn;
    ctl_t c;
    int nops;

    ops = '{6'h00, 6'h23, 6'h2b, 6'h0d, 6'h04, 6'h02, 6'h3f};
`ifdef ILLEGAL_TRAP_EN
    nops = 6;
`else
    nops = 7;
`endif

    mem_ready = 1'b1;
    #2;
    chk("reset_ctl", {14'b0, obs}, 32'd0);
    chk("reset_retired", 32'(retired), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    run_instr(6'h00, 6'h20, 0, 0, 1'b0);
    run_instr(6'h00, 6'h22, 1, 0, 1'b0);
    run_instr(6'h23, 6'h00, 0, 3, 1'b0);
    run_instr(6'h04, 6'h00, 0, 0, 1'b1);
    run_instr(6'h04, 6'h00, 0, 0, 1'b0);
`ifndef ILLEGAL_TRAP_EN
    run_instr(6'h3f, 6'h00, 0, 0, 1'b0);
`endif
    run_instr(6'h2b, 6'h00, 3, 2, 1'b0);

    for (int n = 0; n < 60; n++) begin
      fns = '{6'h20, 6'h22, 6'h25, 6'($urandom)};
      op = ops[$urandom_range(0, nops - 1)];
      fn = fns[$urandom_range(0, 3)];
      run_instr(op, fn, $urandom_range(0, 3), $urandom_range(0, 3), rb());
    end

    // Reset asserted mid-cycle while a store is waiting on memory.
    opcode = 6'h2b;
    mem_wait("fetch", v_fetch(), 1'b1, 0);
    c = '0; c.alu_src_b = 2'b11;
    step("decode", rb(), rb(), c);
    c = '0; c.alu_src_a = 1'b1; c.alu_src_b = 2'b10;
    step("mem_addr", rb(), rb(), c);
    mem_ready = 1'b0;
    #1;
    c = '0; c.mem_req = 1'b1; c.mem_we = 1'b1; c.iord = 1'b1;
    chk("mem_wr_hold", {14'b0, obs}, {14'b0, c});
    #1;
    rst = 1'b1;
    #1;
    chk("rst_async_req", 32'(mem_req), 32'd0);
    chk("rst_async_we", 32'(mem_we), 32'd0);
    reset_pulse();
    step("post_rst_fetch", 1'b0, rb(), v_fetch());

    // Memory never answers in fetch: timeout after TO wait cycles, error sticks.
    reset_pulse();
    for (int i = 0; i < TO; i++) step("to_fetch", 1'b0, rb(), v_fetch());
    c = '0; c.err = 1'b1;
    for (int i = 0; i < 3; i++) step("error_sticky", rb(), rb(), c);
    reset_pulse();
    chk("err_cleared", 32'(err), 32'd0);
    step("fetch_after_err", 1'b0, rb(), v_fetch());

`ifdef ILLEGAL_TRAP_EN
    reset_pulse();
    opcode = 6'h3f;
    mem_wait("fetch", v_fetch(), 1'b1, 0);
    c = '0; c.alu_src_b = 2'b11;
    step("decode", rb(), rb(), c);
    for (int i = 0; i < 3; i++) begin
      mem_ready = rb();
      #1;
      chk("trap_out", 32'(trap), 32'd1);
      step("trap_ctl", mem_ready, rb(), '0);
    end
    chk("trap_retired", 32'(retired), 32'(exp_ret));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
